// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets (decoded from busAddr[3:2]), STATUS/CTRL bit
// positions, and the serializer state encoding.
package uart_tx_pkg;

    // Word offsets: the value of busAddr[3:2] for each register
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// tx_fifo: synchronous FIFO with push, pop and flush.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push, wdata       - write request and data (ignored when full unless popping)
//   pop               - read request (ignored when empty); rdata shows the head
//   flush             - empties the FIFO; overrides push and pop in that cycle
//   full, empty, count - occupancy flags and entry count
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still succeeds when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: bus-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   sel         - peripheral select from the address decoder
//   busWe       - write enable (write happens when sel && busWe)
//   busAddr     - byte address, only [3:2] decoded
//   busWData    - write data
//   busRData    - combinational read data, 0 when not selected
//   tx          - serial line, idles high
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        tx
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             en;
    logic             ovf;

    logic [1:0]       reg_sel;
    logic             wr_en;
    logic             push;
    logic             flush;
    logic             pop;
    logic             bit_end;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status;
    logic             unused_bits;

    assign reg_sel = busAddr[3:2];
    assign wr_en   = sel && busWe;
    assign push    = wr_en && (reg_sel == ADDR_DATA);
    assign flush   = wr_en && (reg_sel == ADDR_CTRL) && busWData[CTRL_FLUSH];
    assign bit_end = (baud_cnt == '0);
    // Head is taken either from IDLE or on the last cycle of a stop bit,
    // which is what makes back-to-back frames gapless
    assign pop     = en && !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    assign unused_bits = ^{busAddr[31:4], busAddr[1:0], busWData};

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (busWData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_W'(DEFAULT_DIV);
            en      <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == ADDR_DIV))  div_reg <= busWData[DIV_W-1:0];
            if (wr_en && (reg_sel == ADDR_CTRL)) en      <= busWData[CTRL_EN];
            if (push && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr_en && (reg_sel == ADDR_STATUS) && busWData[STAT_OVF])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        status                           = '0;
        status[STAT_BUSY]                = (state != IDLE);
        status[STAT_FULL]                = fifo_full;
        status[STAT_EMPTY]               = fifo_empty;
        status[STAT_OVF]                 = ovf;
        status[STAT_COUNT_LSB +: 4]      = 4'(fifo_count);
    end

    always_comb begin
        busRData = '0;
        if (sel) begin
            case (reg_sel)
                ADDR_STATUS: busRData = status;
                ADDR_DIV:    busRData = 32'(div_reg);
                ADDR_CTRL:   busRData[CTRL_EN] = en;
                default:     busRData = '0;
            endcase
        end
    end

    // Serializer FSM; tx is registered so it never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        tx       <= 1'b0;
                        baud_cnt <= div_reg;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx       <= shreg[0];
                        baud_cnt <= div_reg;
                        bit_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div_reg;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // shreg shifts on this same edge, so bit 1 is the next bit out
                            tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state    <= START;
                            tx       <= 1'b0;
                            baud_cnt <= div_reg;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Shift register holds payload only; it is reloaded on every pop
    always_ff @(posedge clk) begin
        if (pop)
            shreg <= fifo_rdata;
        else if ((state == DATA) && bit_end)
            shreg <= {1'b0, shreg[7:1]};
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: stimulus pushes expected bytes into
// exp_q; a line monitor decodes frames on tx and compares against the queue.
module tb_uart_tx_periph;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        tx;

    typedef struct {
        logic [7:0] data;
        bit         contig;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   cur_div;
    bit   mon_abort;

    uart_tx_periph #(
        .FIFO_DEPTH  (4),
        .DIV_W       (16),
        .DEFAULT_DIV (867)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busRData (busRData),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        sel      = 1'b1;
        busWe    = 1'b1;
        busAddr  = {28'd0, r, 2'b00};
        busWData = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        busWe = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] r, input logic [31:0] exp);
        logic [31:0] v;
        sel     = 1'b1;
        busWe   = 1'b0;
        busAddr = {28'd0, r, 2'b00};
        #1;
        v   = busRData;
        sel = 1'b0;
        check(name, v, exp);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit expect_frame, input bit contig);
        exp_t e;
        e.data   = b;
        e.contig = contig;
        if (expect_frame) exp_q.push_back(e);
        wr(2'd0, {24'd0, b});
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d frames outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Line monitor: sample at negedge, decode one frame per falling start bit
    initial begin : monitor
        int         gap;
        int         d;
        logic [9:0] bits;
        bit         glitch;
        bit         aborted;
        exp_t       e;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (tx !== 1'b0 || reset) begin
                if (gap < 1000) gap++;
            end else begin
                d       = cur_div;
                glitch  = 1'b0;
                aborted = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c <= d; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (mon_abort || reset) aborted = 1'b1;
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) glitch = 1'b1;
                    end
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", 32'(bits[8:1]), 32'(e.data));
                        check("stop_bit", 32'(bits[9]), 32'd1);
                        check("bit_stable", 32'(glitch), 32'd0);
                        if (e.contig) check("no_gap", 32'(gap), 32'd0);
                    end
                end
                gap = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tests     = 0;
        fails     = 0;
        cur_div   = 867;
        mon_abort = 1'b0;
        reset     = 1'b1;
        sel       = 1'b0;
        busWe     = 1'b0;
        busAddr   = '0;
        busWData  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("tx_in_reset", 32'(tx), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk_reg("rst_status", 2'd1, 32'h04);
        chk_reg("rst_div", 2'd2, 32'd867);
        chk_reg("rst_ctrl", 2'd3, 32'h1);
        chk_reg("rst_data", 2'd0, 32'h0);

        // Single frame 0x55 at DIV=3, latency and frame length
        cur_div = 3;
        wr(2'd2, 32'd3);
        chk_reg("div_readback", 2'd2, 32'd3);
        push_byte(8'h55, 1'b1, 1'b0);
        chk_reg("t1_status_push", 2'd1, 32'h10);
        check("t1_tx_before_pop", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk_reg("t1_status_pop", 2'd1, 32'h05);
        check("t1_tx_start", 32'(tx), 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk_reg("t1_status_last", 2'd1, 32'h05);
        check("t1_tx_stop", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk_reg("t1_status_done", 2'd1, 32'h04);
        drain("t1_drain", 100);

        // Back-to-back frames at DIV=0
        cur_div = 0;
        wr(2'd2, 32'd0);
        push_byte(8'hA5, 1'b1, 1'b0);
        push_byte(8'h3C, 1'b1, 1'b1);
        push_byte(8'hFF, 1'b1, 1'b1);
        drain("t2_drain", 200);
        repeat (3) @(posedge clk);
        #1;
        chk_reg("t2_status_done", 2'd1, 32'h04);

        // EN=0 fill and overflow, OVF clear, then drain in order
        cur_div = 1;
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd0);
        push_byte(8'h11, 1'b1, 1'b0);
        chk_reg("t3_count1", 2'd1, 32'h10);
        push_byte(8'h22, 1'b1, 1'b1);
        push_byte(8'h33, 1'b1, 1'b1);
        push_byte(8'h44, 1'b1, 1'b1);
        push_byte(8'h66, 1'b0, 1'b0);
        chk_reg("t3_full_ovf", 2'd1, 32'h4A);
        check("t3_tx_idle", 32'(tx), 32'd1);
        wr(2'd1, 32'h8);
        chk_reg("t3_ovf_clear", 2'd1, 32'h42);
        wr(2'd3, 32'd1);
        drain("t3_drain", 400);
        repeat (3) @(posedge clk);
        #1;
        chk_reg("t3_status_done", 2'd1, 32'h04);

        // FLUSH mid-frame with three bytes queued
        cur_div = 3;
        wr(2'd2, 32'd3);
        push_byte(8'h81, 1'b1, 1'b0);
        push_byte(8'h82, 1'b0, 1'b0);
        push_byte(8'h83, 1'b0, 1'b0);
        push_byte(8'h84, 1'b0, 1'b0);
        chk_reg("t4_queued", 2'd1, 32'h31);
        repeat (12) @(posedge clk);
        wr(2'd3, 32'h3);
        chk_reg("t4_after_flush", 2'd1, 32'h05);
        drain("t4_drain", 200);
        repeat (50) @(posedge clk);
        #1;
        chk_reg("t4_idle_empty", 2'd1, 32'h04);
        check("t4_tx_idle", 32'(tx), 32'd1);

        // Pending byte discarded by FLUSH before it can be sent
        wr(2'd3, 32'd0);
        push_byte(8'h99, 1'b0, 1'b0);
        wr(2'd3, 32'h2);
        chk_reg("t4_flush_pending", 2'd1, 32'h04);
        wr(2'd3, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk_reg("t4_no_frame", 2'd1, 32'h04);

        // Reset in the middle of data bit 0
        mon_abort = 1'b1;
        push_byte(8'hF0, 1'b0, 1'b0);
        push_byte(8'h00, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_tx_data0", 32'(tx), 32'd0);
        chk_reg("t5_status_busy", 2'd1, 32'h11);
        #1;
        reset = 1'b1;
        #1;
        check("t5_tx_async", 32'(tx), 32'd1);
        chk_reg("t5_status_rst", 2'd1, 32'h04);
        chk_reg("t5_div_rst", 2'd2, 32'd867);
        chk_reg("t5_ctrl_rst", 2'd3, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        cur_div   = 867;
        mon_abort = 1'b0;
        #1;
        check("t5_tx_after", 32'(tx), 32'd1);

        // Unselected write is ignored and reads return 0
        @(negedge clk);
        sel      = 1'b0;
        busWe    = 1'b1;
        busAddr  = 32'h0;
        busWData = 32'h77;
        #1;
        check("t6_rdata_unsel", busRData, 32'h0);
        busAddr = 32'h4;
        #1;
        check("t6_status_unsel", busRData, 32'h0);
        busAddr = 32'h0;
        @(posedge clk);
        #1;
        busWe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reg("t6_no_push", 2'd1, 32'h04);
        check("t6_tx_idle", 32'(tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter that acts as a bus responder on the CPU data bus (`busWe`/`busAddr`/`busWData`/`busRData`). Software pushes bytes into a small TX FIFO and reads status. A serializer drains the FIFO onto a standard 8N1 line at a programmable baud divisor. It sits behind the bus interconnect's address decoder alongside RAM and other peripherals.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, at least 2.
- `DIV_W`, 16: width of the baud divisor register.
- `DEFAULT_DIV`, 867: reset divisor. Bit period is DIV+1 cycles; 868 cycles gives 115200 baud at 100 MHz.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `sel`  in  1  peripheral select from the interconnect decoder.
- `busWe`  in  1  write enable; a write occurs only when `sel && busWe`.
- `busAddr`  in  32  byte address; only `busAddr[3:2]` is decoded.
- `busWData`  in  32  write data.
- `busRData`  out  32  read data; combinational from `busAddr`; 0 when `sel`=0.
- `tx`  out  1  serial output; idles high.

## Operation
Register map, by offset:
- 0x0 DATA
  - Write pushes `busWData[7:0]` into the FIFO. Reads return 0.
  - Push while full: byte is dropped and sticky OVF is set.
  - Push with simultaneous pop while full: both succeed; count is unchanged.
- 0x4 STATUS, read-only except OVF clear.
  - Bit 0 BUSY: FSM is not in IDLE.
  - Bit 1 FULL.
  - Bit 2 EMPTY.
  - Bit 3 OVF.
  - Bits [7:4] COUNT.
  - Writing with bit 3 = 1 clears OVF.
- 0x8 BAUDDIV: R/W, `[DIV_W-1:0]`. A new value is used from the next bit-period reload; the bit currently in flight is unaffected.
- 0xC CTRL
  - Bit 0 EN: R/W, reset value 1.
  - Bit 1 FLUSH: write-1 pulse that empties the FIFO. Reads as 0.
  - FLUSH and push in the same write cycle: flush wins and the byte is discarded.
- Reads have no side effects. Unused bits read 0.

FSM states and transitions:
- IDLE → START when EN=1 and FIFO is not empty. Pop the head into the shift register and load the baud counter.
- START (`tx`=0) → DATA after DIV+1 cycles.
- DATA shifts 8 bits, LSB first, each for DIV+1 cycles. It moves to STOP when the 3-bit bit counter wraps from 7.
- STOP (`tx`=1) lasts DIV+1 cycles. At the end, if EN=1 and the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.

Baud counter: counts down from DIV to 0; the bit ends on the cycle the counter reaches 0. DIV=0 gives 1-cycle bits and is legal.

Boundary rules:
- EN cleared mid-frame: the current frame completes; no new frame starts.
- FLUSH mid-frame: the frame in the shift register completes; the queued bytes are lost.
- Reset mid-frame: `tx`=1 immediately; the FIFO is emptied.

Reset values:
- `tx`=1, FSM in IDLE, FIFO empty, OVF=0.
- BAUDDIV=DEFAULT_DIV, EN=1.
- `busRData` follows the register contents.

## Timing
- Write takes effect at the clock edge where `sel && busWe`.
- Push into an empty FIFO while IDLE at edge T: the pop happens at edge T+1, and `tx` falls after T+1.
- BUSY=1 from the edge after the pop.
- A frame is exactly 10×(DIV+1) cycles. Back-to-back frames have no gap.
- COUNT reflects a push or pop one cycle after its edge.
- Read path is zero-latency combinational, as required by the single-cycle core.

## Structure
- Package `uart_tx_pkg` holds:
  - Address offset localparams: `ADDR_DATA`, `ADDR_STATUS`, `ADDR_DIV`, `ADDR_CTRL`.
  - STATUS and CTRL bit-position constants.
  - The `tx_state_e` enum: IDLE, START, DATA, STOP.
- Sub-module `tx_fifo`: synchronous FIFO with push/pop/flush, full/empty and count outputs, parameterised by depth and width.
- The top level holds the register decode, baud counter, bit counter, shift register and FSM.

## Test plan
- Reset, DIV=3, write 0x55 to DATA → `tx` shows start bit 0, then 1,0,1,0,1,0,1,0, then stop 1; each bit 4 cycles, frame 40 cycles; then BUSY=0 and EMPTY=1.
- DIV=0, push 0xA5, 0x3C, 0xFF back-to-back → three contiguous 10-cycle frames, with no high gap between the stop bit and the next start bit.
- EN=0, push 5 bytes → COUNT=4, FULL=1, OVF=1, `tx` stays high. Write 0x8 to STATUS → OVF=0. Set EN=1 → 4 frames in FIFO order.
- FLUSH at cycle 15 of frame 1 with 3 bytes queued → frame 1 completes, then IDLE with EMPTY=1; a push and FLUSH in the same write cycle leaves the FIFO empty.
- Assert `reset` mid-data-bit → `tx`=1 asynchronously, STATUS reads 0x4, BAUDDIV reads DEFAULT_DIV.
- `sel`=0 with `busWe`=1 to DATA → no push; `busRData`=0.
